// File: rtl/avalon_pio_out_pulse.sv
`default_nettype none
// ============================================================================
// Module      : avalon_pio_out_pulse
// Description : Avalon-MM slave output port. The data register can be
//               written whole, set bit-wise or cleared bit-wise. A pulse
//               register raises selected bits for exactly PULSE_CYCLES
//               clocks and then clears them automatically.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_pio_out_pulse #(
    parameter int               WIDTH        = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               PULSE_CYCLES = 50000,
    parameter int               CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [1:0] c_ADDR_DATA  = 2'd0;
    localparam logic [1:0] c_ADDR_SET   = 2'd1;
    localparam logic [1:0] c_ADDR_CLR   = 2'd2;
    localparam logic [1:0] c_ADDR_PULSE = 2'd3;

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_ACTIVE = 1'b1;

    localparam logic [CNT_W-1:0] c_PULSE = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_mask;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic [0:0]       w_state_nx;
    logic [WIDTH-1:0] w_data_nx;
    logic [WIDTH-1:0] w_mask_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_done_nx;

    logic             w_wr;
    logic             w_busy;
    logic             w_expire;
    logic [WIDTH-1:0] w_wd;
    logic             w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_wd           = writedata[WIDTH-1:0];
    assign w_busy         = (r_state == c_ACTIVE);
    assign w_expire       = w_busy && (r_cnt == c_ONE);
    assign w_unused_wdata = ^writedata;
    assign out_port       = r_data;

    // State register for data, pulse mask, counter, FSM state and done flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_data  <= RESET_VALUE;
            r_mask  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_data  <= w_data_nx;
            r_mask  <= w_mask_nx;
            r_cnt   <= w_cnt_nx;
            r_done  <= w_done_nx;
        end
    end

    // Next state: pulse countdown/expiry first, then any bus write on top
    always_comb begin
        w_state_nx = r_state;
        w_data_nx  = r_data;
        w_mask_nx  = r_mask;
        w_cnt_nx   = r_cnt;
        w_done_nx  = r_done;

        if (w_expire) begin
            w_data_nx  = r_data & ~r_mask;
            w_mask_nx  = '0;
            w_cnt_nx   = '0;
            w_state_nx = c_IDLE;
            w_done_nx  = 1'b1;
        end else if (w_busy) begin
            w_cnt_nx = r_cnt - c_ONE;
        end

        if (w_wr) begin
            case (address)
                c_ADDR_DATA: w_data_nx = w_wd;
                c_ADDR_SET:  w_data_nx = w_data_nx | w_wd;
                c_ADDR_CLR:  w_data_nx = w_data_nx & ~w_wd;
                default: begin
                    // A zero pulse write leaves everything alone, done included.
                    // After expiry w_mask_nx is already zero, so the new mask
                    // is just wd in that case.
                    if (w_wd != '0) begin
                        w_data_nx  = w_data_nx | w_wd;
                        w_mask_nx  = w_mask_nx | w_wd;
                        w_cnt_nx   = c_PULSE;
                        w_state_nx = c_ACTIVE;
                        w_done_nx  = 1'b0;
                    end
                end
            endcase
        end
    end

    // Zero-wait-state read mux; SET and CLR read as zero
    always_comb begin
        readdata = '0;
        case (address)
            c_ADDR_DATA:  readdata[WIDTH-1:0] = r_data;
            c_ADDR_PULSE: readdata[31:30]     = {w_busy, r_done};
            default:      readdata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_pio_out_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_pio_out_pulse
// Description : Scoreboard bench for avalon_pio_out_pulse (WIDTH=4,
//               RESET_VALUE=4'b0001, PULSE_CYCLES=5). Each stimulus cycle
//               pushes the expected out_port/readdata; a monitor pops and
//               compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_pio_out_pulse;

    localparam logic [1:0] A_DATA  = 2'd0;
    localparam logic [1:0] A_SET   = 2'd1;
    localparam logic [1:0] A_CLR   = 2'd2;
    localparam logic [1:0] A_PULSE = 2'd3;
    localparam logic [31:0] BUSY   = 32'h8000_0000;
    localparam logic [31:0] DONE   = 32'h4000_0000;

    typedef struct {
        string       name;
        logic [3:0]  exp_out;
        logic [31:0] exp_rd;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    exp_t q[$];
    int   total;
    int   bad;

    avalon_pio_out_pulse #(
        .WIDTH        (4),
        .RESET_VALUE  (4'b0001),
        .PULSE_CYCLES (5),
        .CNT_W        (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: drive inputs just after the rising edge and record what
    // the DUT must show during this cycle (state left by the previous edge).
    task automatic cyc(input string nm, input logic rs, input logic wr,
                       input logic [1:0] a, input logic [31:0] wd,
                       input logic [3:0] eo, input logic [31:0] erd);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rs;
        chipselect = wr;
        write_n    = ~wr;
        address    = a;
        writedata  = wd;
        e.name     = nm;
        e.exp_out  = eo;
        e.exp_rd   = erd;
        q.push_back(e);
    endtask

    // Monitor: compare on the falling edge whenever an expectation is queued
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total = total + 1;
            if (out_port !== e.exp_out) begin
                bad = bad + 1;
                $display("FAIL %s out_port: got %b want %b", e.name, out_port, e.exp_out);
            end
            total = total + 1;
            if (readdata !== e.exp_rd) begin
                bad = bad + 1;
                $display("FAIL %s readdata: got %h want %h", e.name, readdata, e.exp_rd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1: reset state
        cyc("rst_data",   0, 0, A_DATA,  0, 4'b0001, 32'h1);
        cyc("rst_pulse",  0, 0, A_PULSE, 0, 4'b0001, 32'h0);

        // 2: DATA / SET / CLR
        cyc("wr_data_a",  0, 1, A_DATA,  32'hA, 4'b0001, 32'h1);
        cyc("wr_set_4",   0, 1, A_SET,   32'h4, 4'b1010, 32'h0);
        cyc("wr_clr_8",   0, 1, A_CLR,   32'h8, 4'b1110, 32'h0);
        cyc("wr_data_hi", 0, 1, A_DATA,  32'hFFFF_FFF3, 4'b0110, 32'h6);
        cyc("data_trunc", 0, 0, A_DATA,  0, 4'b0011, 32'h3);

        // 3: single pulse of bit1, then a zero pulse write
        cyc("data_zero",  0, 1, A_DATA,  0, 4'b0011, 32'h3);
        cyc("pulse_2",    0, 1, A_PULSE, 32'h2, 4'b0000, 32'h0);
        for (int i = 0; i < 5; i++)
            cyc("p2_high", 0, 0, A_PULSE, 0, 4'b0010, BUSY);
        cyc("p2_expire",  0, 1, A_PULSE, 32'h0, 4'b0000, DONE);
        cyc("done_kept",  0, 0, A_PULSE, 0, 4'b0000, DONE);

        // 4: retrigger extends pulse of bit0 to the second write
        cyc("pulse_1",    0, 1, A_PULSE, 32'h1, 4'b0000, DONE);
        cyc("p1_a",       0, 0, A_PULSE, 0, 4'b0001, BUSY);
        cyc("p1_b",       0, 0, A_PULSE, 0, 4'b0001, BUSY);
        cyc("pulse_4",    0, 1, A_PULSE, 32'h4, 4'b0001, BUSY);
        for (int i = 0; i < 5; i++)
            cyc("p14_high", 0, 0, A_PULSE, 0, 4'b0101, BUSY);

        // 5a: CLR ends a pulse bit early, busy lasts until expiry
        cyc("pulse_8",    0, 1, A_PULSE, 32'h8, 4'b0000, DONE);
        cyc("p8_a",       0, 0, A_PULSE, 0, 4'b1000, BUSY);
        cyc("clr_8",      0, 1, A_CLR,   32'h8, 4'b1000, 32'h0);
        cyc("p8_cleared", 0, 0, A_PULSE, 0, 4'b0000, BUSY);
        cyc("p8_busy_a",  0, 0, A_PULSE, 0, 4'b0000, BUSY);
        cyc("p8_busy_b",  0, 0, A_PULSE, 0, 4'b0000, BUSY);

        // 5b: DATA write on the exact expiry edge survives
        cyc("pulse_8b",   0, 1, A_PULSE, 32'h8, 4'b0000, DONE);
        for (int i = 0; i < 4; i++)
            cyc("p8b_high", 0, 0, A_PULSE, 0, 4'b1000, BUSY);
        cyc("data_8_exp", 0, 1, A_DATA,  32'h8, 4'b1000, 32'h8);
        cyc("after_exp",  0, 0, A_PULSE, 0, 4'b1000, DONE);

        // 6: reset in the middle of a pulse
        cyc("pulse_2b",   0, 1, A_PULSE, 32'h2, 4'b1000, DONE);
        cyc("p2b_a",      0, 0, A_PULSE, 0, 4'b1010, BUSY);
        cyc("p2b_b",      0, 0, A_PULSE, 0, 4'b1010, BUSY);
        cyc("p2b_rst",    1, 0, A_PULSE, 0, 4'b1010, BUSY);
        for (int i = 0; i < 7; i++)
            cyc("post_rst", 0, 0, A_PULSE, 0, 4'b0001, 32'h0);
        cyc("post_rst_d", 0, 0, A_DATA,  0, 4'b0001, 32'h1);

        @(negedge clk);
        #1;
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avalon_pio_out_pulse.md
Name: avalon_pio_out_pulse

Overview:
- Parametrised Avalon-MM slave output port. It drives a WIDTH-bit out_port from a register that software can write whole, set bit-wise or clear bit-wise.
- It adds a hardware-timed pulse mode. Selected bits are asserted for exactly PULSE_CYCLES clocks and then auto-cleared, for reset-style strobes such as USB controller reset without software delay loops.
- Sits on the system interconnect beside the other peripheral slaves.

Parameters:
- WIDTH, 1: out_port width in bits; legal range 1..32.
- RESET_VALUE, 0: out_port value after reset; WIDTH bits.
- PULSE_CYCLES, 50000: pulse length in clk cycles (1 ms at 50 MHz); must be >= 1 and < 2^31.
- CNT_W, 32: pulse counter width; must hold PULSE_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  word address of the register being accessed.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH are ignored.
- readdata  out  32  read data; combinational, zero wait states.
- out_port  out  WIDTH  output pins, driven directly from the data register.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- wr = chipselect & ~write_n. Every write completes in one cycle.
- Register map:
  - 0 DATA (rw): write loads data = wd. Read returns data, zero-extended.
  - 1 SET (wo): write gives data = data | wd. Reads return 0.
  - 2 CLR (wo): write gives data = data & ~wd. Reads return 0.
  - 3 PULSE (rw): write starts a pulse on bits wd. Read returns {busy, done, 30'b0}.
  - Here wd = writedata[WIDTH-1:0].
- Reset, asserted at any clk edge including mid-pulse:
  - data = RESET_VALUE, mask = 0, cnt = 0, busy = 0, done = 0.
  - out_port = RESET_VALUE from the following cycle.
- Pulse state machine, states IDLE (busy=0) and ACTIVE (busy=1):
  - PULSE write with wd != 0:
    - data |= wd, mask = wd (IDLE) or mask | wd (ACTIVE), cnt = PULSE_CYCLES.
    - busy = 1, done = 0.
    - A write in ACTIVE restarts the count (retrigger).
  - PULSE write with wd == 0: no effect, including no effect on done.
  - ACTIVE, cnt > 1: cnt decrements each cycle.
  - ACTIVE, cnt == 1 (expiry edge): data &= ~mask, mask = 0, cnt = 0, busy = 0, done = 1 → IDLE.
  - Net effect: a pulse bit is high for exactly PULSE_CYCLES cycles after the write edge.
  - done is sticky. It is cleared only by a qualifying PULSE write or by reset.
- Simultaneous events, expiry applied first and the write applied to the result:
  - DATA/SET/CLR write on the expiry edge: data_next = write_op(data & ~mask).
  - PULSE write on the expiry edge: new pulse with mask = wd only, busy stays 1, done = 0.
  - DATA/SET/CLR during ACTIVE: applied immediately. Pulse bits still clear at expiry, so CLR can end a pulse bit early and SET of a mask bit is undone at expiry. mask and cnt are unaffected.
- readdata = 0 when address selects SET or CLR. readdata is independent of chipselect.
- Bits of writedata above WIDTH are ignored. Read bits above WIDTH return 0.

Test Plan:
All scenarios use WIDTH=4, RESET_VALUE=4'b0001, PULSE_CYCLES=5.
1. Assert reset 2 cycles then release → out_port=0001; addr0 reads 0x1; addr3 reads 0x0.
2. Write DATA 0xA; SET 0x4; CLR 0x8 → out_port 1010, then 1110, then 0110; addr1/addr2 read 0; write DATA 0xFFFFFFF3 → out_port 0011.
3. From DATA=0, write PULSE 0x2 → out_port=0010 for exactly 5 cycles, then 0000. addr3 reads 0x80000000 during the pulse and 0x40000000 after. Write PULSE 0x0 → done remains set.
4. Write PULSE 0x1; 3 cycles later write PULSE 0x4 → bit0 and bit2 both clear 5 cycles after the second write; bit2 is high for 5 cycles.
5. Write PULSE 0x8; 2 cycles later CLR 0x8 → bit3 low early, busy persists until expiry. Repeat with a DATA write of 0x8 on the exact expiry edge → out_port=1000 afterwards.
6. Write PULSE 0x2; assert reset at cycle 3 → out_port=0001, busy=0, done=0; no later expiry alters data.
